// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU and MTHI/MTLO sequencer
// driving a single-cycle HI/LO write; busy_o stalls the pipeline while in flight.
module hilo_muldiv_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] hi_cur_i,
    input  logic [DATA_WIDTH-1:0] lo_cur_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  hilo_we_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MUL  = 3'd1;
    localparam logic [2:0] DIV  = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] WB   = 3'd4;

    logic [2:0]     state;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   dvs;
    logic           sign_q, sign_r, is_div;

    logic           is_signed, last, div_ge;
    logic [W-1:0]   a_mag, b_mag, div_diff, q_fix, r_fix;
    logic [W:0]     mul_sum, div_sh;
    logic [2*W-1:0] prod_fix;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        is_signed = ~op_i[0];
        a_mag     = (is_signed && a_i[W-1]) ? -a_i : a_i;
        b_mag     = (is_signed && b_i[W-1]) ? -b_i : b_i;
        last      = cnt == CW'(W - 1);
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? dvs : {W{1'b0}}};
        div_sh    = acc[2*W-1:W-1];
        div_ge    = div_sh >= {1'b0, dvs};
        div_diff  = div_sh[W-1:0] - dvs;
        prod_fix  = sign_q ? -acc : acc;
        q_fix     = sign_q ? -acc[W-1:0] : acc[W-1:0];
        r_fix     = sign_r ? -acc[2*W-1:W] : acc[2*W-1:W];
    end

    assign busy_o    = state != IDLE;
    assign hilo_we_o = (state == WB) && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            dvs    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            is_div <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else if (state != IDLE && flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start_i && !flush_i) begin
                    cnt    <= '0;
                    sign_q <= is_signed && (a_i[W-1] ^ b_i[W-1]);
                    sign_r <= is_signed && a_i[W-1];
                    is_div <= op_i[1];
                    dvs    <= op_i[1] ? b_mag : a_mag;
                    acc    <= {{W{1'b0}}, op_i[1] ? a_mag : b_mag};
                    case (op_i)
                        3'd0, 3'd1: state <= MUL;
                        3'd2, 3'd3: if (b_i == '0) begin
                            state <= WB;
                            hi_o  <= a_i;
                            lo_o  <= '1;
                        end else begin
                            state <= DIV;
                        end
                        3'd4: begin
                            state <= WB;
                            hi_o  <= a_i;
                            lo_o  <= lo_cur_i;
                        end
                        3'd5: begin
                            state <= WB;
                            hi_o  <= hi_cur_i;
                            lo_o  <= a_i;
                        end
                        default: state <= IDLE;
                    endcase
                end
                MUL: begin
                    acc   <= {mul_sum, acc[W-1:1]};
                    cnt   <= cnt + CW'(1);
                    state <= last ? FIX : MUL;
                end
                DIV: begin
                    acc   <= {div_ge ? div_diff : div_sh[W-1:0], acc[W-2:0], div_ge};
                    cnt   <= cnt + CW'(1);
                    state <= last ? FIX : DIV;
                end
                FIX: begin
                    hi_o  <= is_div ? r_fix : prod_fix[2*W-1:W];
                    lo_o  <= is_div ? q_fix : prod_fix[W-1:0];
                    state <= WB;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: randomized and directed checks of hilo_muldiv_ctrl against
// a plain-arithmetic HI/LO reference model.
module tb_hilo_muldiv_ctrl;
    logic        clk = 0, rst = 0, start_i = 0, flush_i = 0;
    logic [2:0]  op_i = 0;
    logic [31:0] a_i = 0, b_i = 0, hi_cur_i = 0, lo_cur_i = 0;
    logic        busy_o, hilo_we_o;
    logic [31:0] hi_o, lo_o;
    int checks = 0, failures = 0;

    hilo_muldiv_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .hi_cur_i(hi_cur_i), .lo_cur_i(lo_cur_i), .flush_i(flush_i),
        .busy_o(busy_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a, b, hc, lc,
                                  output logic wr, output logic [31:0] hi, lo, output int lat);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        wr = 1; lat = 34; hi = 0; lo = 0; p = 0;
        case (op)
            3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; lat = 1; end
                else if (op == 3'd2) begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
                else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
            end
            3'd4: begin hi = a; lo = lc; lat = 1; end
            3'd5: begin hi = hc; lo = a; lat = 1; end
            default: begin wr = 0; lat = 0; end
        endcase
    endfunction

    // Called at a negedge; drives start for one cycle and watches 40 cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, hc, lc);
        logic wr;
        logic [31:0] eh, el, gh, gl;
        int lat, first, nwe, nbusy;
        model(op, a, b, hc, lc, wr, eh, el, lat);
        first = -1; nwe = 0; nbusy = 0; gh = 0; gl = 0;
        start_i = 1; op_i = op; a_i = a; b_i = b; hi_cur_i = hc; lo_cur_i = lc;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_i = 0;
            if (busy_o) nbusy++;
            if (hilo_we_o) begin
                nwe++;
                if (first < 0) begin first = k; gh = hi_o; gl = lo_o; end
            end
        end
        chk($sformatf("writes op%0d", op), 64'(nwe), 64'(wr));
        chk($sformatf("latency op%0d", op), 64'(first), wr ? 64'(lat) : 64'(-1));
        chk($sformatf("busy_cycles op%0d", op), 64'(nbusy), 64'(lat));
        if (wr) begin
            chk($sformatf("hi op%0d a=%h b=%h", op, a, b), 64'(gh), 64'(eh));
            chk($sformatf("lo op%0d a=%h b=%h", op, a, b), 64'(gl), 64'(el));
            chk("hold", {hi_o, lo_o}, {eh, el});
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        return ($urandom_range(0, 3) == 0) ? c[$urandom_range(0, 5)] : $urandom;
    endfunction

    initial begin
        logic wr;
        logic [31:0] eh, el;
        int lat, nwe, nbusy;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy_o), 64'(0));
        chk("reset we", 64'(hilo_we_o), 64'(0));
        chk("reset hilo", {hi_o, lo_o}, 64'(0));
        rst = 1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFE, 32'h3, 0, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 0, 0);
        run_op(3'd3, 32'h7, 32'h2, 0, 0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd3, 32'h1234, 32'h0, 0, 0);
        run_op(3'd4, 32'hAA, 32'h0, 32'h11, 32'h55);
        run_op(3'd5, 32'hBB, 32'h0, 32'h66, 32'h22);
        run_op(3'd6, 32'h5, 32'h6, 0, 0);

        // second start while busy is ignored
        model(3'd2, 32'd1000, 32'd7, 0, 0, wr, eh, el, lat);
        start_i = 1; op_i = 3'd2; a_i = 32'd1000; b_i = 32'd7;
        nwe = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_i = (k == 4);
            op_i = (k == 4) ? 3'd4 : 3'd2;
            a_i = (k == 4) ? 32'hDEAD : 32'd1000;
            if (hilo_we_o) begin
                nwe++;
                chk("overlap hi", 64'(hi_o), 64'(eh));
                chk("overlap lo", 64'(lo_o), 64'(el));
            end
        end
        chk("overlap writes", 64'(nwe), 64'(1));

        // flush mid-divide, then restart right away
        start_i = 1; op_i = 3'd3; a_i = 32'd99; b_i = 32'd5;
        nwe = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start_i = 0;
            flush_i = (k == 10);
            if (hilo_we_o) nwe++;
        end
        chk("flush busy", 64'(busy_o), 64'(0));
        chk("flush writes", 64'(nwe), 64'(0));
        run_op(3'd3, 32'd99, 32'd5, 0, 0);

        // flush during WB suppresses the write
        start_i = 1; op_i = 3'd4; a_i = 32'h77; lo_cur_i = 32'h1;
        @(negedge clk);
        start_i = 0; flush_i = 1;
        #1;
        chk("wb flush we", 64'(hilo_we_o), 64'(0));
        @(negedge clk);
        flush_i = 0;
        chk("wb flush busy", 64'(busy_o), 64'(0));

        // start together with flush in IDLE is ignored
        start_i = 1; flush_i = 1; op_i = 3'd5;
        @(negedge clk);
        start_i = 0; flush_i = 0;
        chk("idle flush busy", 64'(busy_o), 64'(0));
        chk("idle flush we", 64'(hilo_we_o), 64'(0));

        // async reset mid-multiply
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
        start_i = 1; op_i = 3'd0; a_i = 32'h7; b_i = 32'h9;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            start_i = 0;
        end
        rst = 0;
        #1;
        chk("arst busy", 64'(busy_o), 64'(0));
        chk("arst we", 64'(hilo_we_o), 64'(0));
        chk("arst hilo", {hi_o, lo_o}, 64'(0));
        repeat (3) @(negedge clk);
        rst = 1;
        nwe = 0; nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hilo_we_o) nwe++;
            if (busy_o) nbusy++;
        end
        chk("arst writes", 64'(nwe), 64'(0));
        chk("arst idle", 64'(nbusy), 64'(0));
        run_op(3'd0, 32'h7, 32'h9, 0, 0);

        for (int n = 0; n < 40; n++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
